wolfram_ca_sched: RTL and testbench

WOLFRAM_CA_SCHED -- requirements
Module: wolfram_ca_sched

---
 rtl/wolfram_ca_pkg.sv | 15 +
 rtl/wolfram_ca_sched_if.sv | 31 +++
 rtl/wolfram_rule_lut.sv | 15 +
 rtl/wolfram_ca_sched.sv | 132 +++++++++++++
 tb/tb_wolfram_ca_sched.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/wolfram_ca_pkg.sv
// Shared types for the Wolfram cellular-automaton scheduler.
//   ca_state_t : scheduler FSM states
//   ca_rule_t  : 8-bit elementary-CA truth table, indexed by {left,self,right}
package wolfram_ca_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } ca_state_t;

  typedef logic [7:0] ca_rule_t;

endpackage

// File: rtl/wolfram_ca_sched_if.sv
// Control/data bundle between a requester and wolfram_ca_sched.
//   start, abort      : run request / cancel
//   rule, seed, gens  : run configuration, sampled when a run is accepted
//   busy, done, cells : run status, completion pulse, committed cell vector
// master = requester side, slave = scheduler side.
interface wolfram_ca_sched_if #(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
);
  import wolfram_ca_pkg::*;

  logic             start;
  logic             abort;
  ca_rule_t         rule;
  logic [WIDTH-1:0] seed;
  logic [GEN_W-1:0] gens;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] cells;

  modport master (
    output start, abort, rule, seed, gens,
    input  busy, done, cells
  );

  modport slave (
    input  start, abort, rule, seed, gens,
    output busy, done, cells
  );

endinterface

// File: rtl/wolfram_rule_lut.sv
// Single elementary-CA rule lookup (purely combinational).
//   rule    : 8-bit truth table
//   nbhd    : {left, self, right} neighbourhood, left is MSB
//   out_bit : rule[nbhd]
module wolfram_rule_lut
  import wolfram_ca_pkg::*;
(
  input  ca_rule_t   rule,
  input  logic [2:0] nbhd,
  output logic       out_bit
);

  assign out_bit = rule[nbhd];

endmodule

// File: rtl/wolfram_ca_sched.sv
// Sequential elementary cellular-automaton engine. One cell is evaluated per
// cycle through a single shared rule lookup into a shadow vector; the shadow
// is committed to the visible cell vector once per generation.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wolfram_ca_sched_if.slave (start/abort/rule/seed/gens in,
//                busy/done/cells out)
// Build option: define WOLFRAM_CA_WRAP_EN for a ring (cell WIDTH-1 and
// cell 0 are neighbours); otherwise cells beyond the edges read as 0.
module wolfram_ca_sched
  import wolfram_ca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  wolfram_ca_sched_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

`ifdef WOLFRAM_CA_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  ca_state_t        state_q, state_d;
  ca_rule_t         rule_q, rule_d;
  logic [WIDTH-1:0] cells_q, cells_d;
  logic [WIDTH-1:0] next_q, next_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GEN_W-1:0] gen_left_q, gen_left_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic left_nb, right_nb, lut_out;

  // Neighbours of cell idx: left is the higher index, right the lower one.
  always_comb begin
    left_nb  = 1'b0;
    right_nb = 1'b0;
    if (idx_q == IDX_LAST) left_nb = WRAP_EN ? cells_q[0] : 1'b0;
    else                   left_nb = cells_q[idx_q + 1'b1];
    if (idx_q == '0)       right_nb = WRAP_EN ? cells_q[WIDTH-1] : 1'b0;
    else                   right_nb = cells_q[idx_q - 1'b1];
  end

  wolfram_rule_lut u_lut (
    .rule    (rule_q),
    .nbhd    ({left_nb, cells_q[idx_q], right_nb}),
    .out_bit (lut_out)
  );

  always_comb begin
    state_d    = state_q;
    rule_d     = rule_q;
    cells_d    = cells_q;
    next_d     = next_q;
    idx_d      = idx_q;
    gen_left_d = gen_left_q;

    case (state_q)
      IDLE: begin
        // start together with abort is treated as no request.
        if (bus.start && !bus.abort) begin
          rule_d     = bus.rule;
          cells_d    = bus.seed;
          gen_left_d = bus.gens;
          idx_d      = '0;
          state_d    = (bus.gens == '0) ? DONE : EVAL;
        end
      end
      EVAL: begin
        next_d[idx_q] = lut_out;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      COMMIT: begin
        cells_d = next_q;
        idx_d   = '0;
        if (gen_left_q != '0) gen_left_d = gen_left_q - 1'b1;
        state_d = (gen_left_q <= GEN_W'(1)) ? DONE : EVAL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a same-cycle commit.
    if ((state_q != IDLE) && bus.abort) begin
      state_d    = IDLE;
      cells_d    = cells_q;
      gen_left_d = gen_left_q;
      idx_d      = '0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rule_q     <= '0;
      cells_q    <= '0;
      next_q     <= '0;
      idx_q      <= '0;
      gen_left_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rule_q     <= rule_d;
      cells_q    <= cells_d;
      next_q     <= next_d;
      idx_q      <= idx_d;
      gen_left_q <= gen_left_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.cells = cells_q;

endmodule

// File: tb/tb_wolfram_ca_sched.sv
// Bench for wolfram_ca_sched at WIDTH=8, GEN_W=8. A timing/arithmetic model of
// a run (cycles since start, generations stepped by a plain CA step function)
// is compared against busy/done/cells on every falling edge; directed runs add
// hand-computed expectations. Honours WOLFRAM_CA_WRAP_EN like the design.
module tb_wolfram_ca_sched;

  localparam int W = 8;

  bit   clk;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  wolfram_ca_sched_if #(.WIDTH(W), .GEN_W(8)) bus ();

  wolfram_ca_sched #(.WIDTH(W), .GEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One generation of an elementary CA: bit i+1 is "left", bit i-1 "right".
  function automatic logic [W-1:0] ca_step(input logic [7:0] r, input logic [W-1:0] c);
    logic [W-1:0] o;
    logic l, s, rt;
    o = '0;
    for (int i = 0; i < W; i++) begin
      s = c[i];
`ifdef WOLFRAM_CA_WRAP_EN
      l  = c[(i + 1) % W];
      rt = c[(i + W - 1) % W];
`else
      l  = (i == W - 1) ? 1'b0 : c[(i + 1) % W];
      rt = (i == 0)     ? 1'b0 : c[(i + W - 1) % W];
`endif
      o[i] = r[{l, s, rt}];
    end
    return o;
  endfunction

  // Run model: m_j counts edges since the accepted start; a generation lands
  // every W+1 edges; done is shown when m_j reaches gens*(W+1).
  bit          m_active;
  int          m_j, m_g;
  logic [7:0]  m_rule;
  logic [W-1:0] m_cur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_j      <= 0;
      m_g      <= 0;
      m_rule   <= '0;
      m_cur    <= '0;
    end else if (!m_active) begin
      if (bus.start && !bus.abort) begin
        m_active <= 1'b1;
        m_j      <= 0;
        m_g      <= int'(bus.gens);
        m_rule   <= bus.rule;
        m_cur    <= bus.seed;
      end
    end else if (bus.abort) begin
      m_active <= 1'b0;
    end else if (m_j == m_g * (W + 1)) begin
      m_active <= 1'b0;
    end else begin
      m_j <= m_j + 1;
      if ((m_j + 1) % (W + 1) == 0) m_cur <= ca_step(m_rule, m_cur);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("mon_busy",  64'(bus.busy),  64'(rst_n ? m_active : 1'b0));
      chk("mon_done",  64'(bus.done),  64'(rst_n && m_active && (m_j == m_g * (W + 1))));
      chk("mon_cells", 64'(bus.cells), 64'(rst_n ? m_cur : '0));
    end
  endtask

  // Issue one run; config inputs are scrambled right after acceptance.
  task automatic run(input logic [7:0] r, input logic [7:0] sd, input logic [7:0] g,
                     output int lat, output int bcnt, output logic [7:0] fc);
    int s;
    bit got;
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b0;
    bus.rule = r; bus.seed = sd; bus.gens = g;
    s = cyc + 1;
    lat = -1; bcnt = 0; fc = '0; got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = 1'b0;
        bus.rule = ~r; bus.seed = ~sd; bus.gens = ~g;
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        got = 1'b1;
        lat = cyc - s + 1;
        fc  = bus.cells;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: no done seen, required within 400 cycles");
    end
    @(negedge clk);
    if (bus.busy) bcnt++;
  endtask

  initial begin
    int lat, bcnt;
    logic [7:0] fc, exp34;
    bit saw_done;

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.rule = '0; bus.seed = '0; bus.gens = '0;
    fork
      monitor();
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(bus.busy),  64'(0));
    chk("rst_done",  64'(bus.done),  64'(0));
    chk("rst_cells", 64'(bus.cells), 64'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(bus.busy), 64'(0));

    // Identity rule holds the seed for every generation.
    run(8'hCC, 8'hA5, 8'd3, lat, bcnt, fc);
    chk("id_latency", 64'(lat), 64'(28));
    chk("id_cells",   64'(fc),  64'(8'hA5));

    // Copy-left: bit 0 moves out of the top (ring) or is lost (null edge).
`ifdef WOLFRAM_CA_WRAP_EN
    exp34 = 8'h80;
`else
    exp34 = 8'h00;
`endif
    run(8'hF0, 8'h01, 8'd1, lat, bcnt, fc);
    chk("copyl_cells",   64'(fc),  64'(exp34));
    chk("copyl_latency", 64'(lat), 64'(10));

    // Rule 90: a single cell spreads to both neighbours.
    run(8'h5A, 8'h10, 8'd1, lat, bcnt, fc);
    chk("r90_cells",   64'(fc),  64'(8'h28));
    chk("r90_latency", 64'(lat), 64'(10));

    // Zero generations: straight to done.
    run(8'h00, 8'h3C, 8'd0, lat, bcnt, fc);
    chk("g0_latency", 64'(lat),  64'(1));
    chk("g0_cells",   64'(fc),   64'(8'h3C));
    chk("g0_busycnt", 64'(bcnt), 64'(1));

    // Multi-generation runs checked by the model only.
    run(8'h1E, 8'h01, 8'd4, lat, bcnt, fc);
    run(8'h6E, 8'h80, 8'd3, lat, bcnt, fc);
    chk("r110_latency", 64'(lat), 64'(28));

    // Abort on cycle 4; a second start during busy must be ignored.
    saw_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.rule = 8'hF0; bus.seed = 8'h01; bus.gens = 8'd2;
    @(negedge clk); bus.start = 1'b0; saw_done |= bus.done;
    @(negedge clk); bus.start = 1'b1; bus.seed = 8'hFF; saw_done |= bus.done;
    @(negedge clk); bus.start = 1'b0; saw_done |= bus.done;
    @(negedge clk); bus.abort = 1'b1; saw_done |= bus.done;
    @(negedge clk); bus.abort = 1'b0; saw_done |= bus.done;
    chk("abort_busy",  64'(bus.busy),  64'(0));
    chk("abort_cells", 64'(bus.cells), 64'(8'h01));
    @(negedge clk); saw_done |= bus.done;
    chk("abort_nodone", 64'(saw_done), 64'(0));
    chk("abort_stays_idle", 64'(bus.busy), 64'(0));

    // start together with abort in IDLE does nothing.
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1; bus.seed = 8'h77; bus.gens = 8'd1;
    @(negedge clk); bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_idle", 64'(bus.busy), 64'(0));

    // Reset in the middle of EVAL.
    @(negedge clk);
    bus.start = 1'b1; bus.rule = 8'hCC; bus.seed = 8'h5A; bus.gens = 8'd2;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(bus.busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy",  64'(bus.busy),  64'(0));
    chk("midrst_done",  64'(bus.done),  64'(0));
    chk("midrst_cells", 64'(bus.cells), 64'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("relrst_busy", 64'(bus.busy), 64'(0));
    chk("relrst_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    chk("relrst_idle", 64'(bus.busy), 64'(0));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
